mem_access_arbiter: RTL and testbench
=====================================

// Module: mem_access_arbiter
// PURPOSE
//  Two-port round-robin arbiter/sequencer in front of the single-port 19-bit Memory_Interface.
//  Port 0 (instruction fetch) and port 1 (load/store unit) each issue read or write requests.
//  The block serialises them onto mem_read/mem_write/address/write_data.
//  It captures the memory's registered read_data and returns it with a one-cycle done pulse.
// PARAMETERS
//  ADDR_W         19  width of request and memory address (memory decodes addr[3:0])
//  DATA_W         19  width of read/write data
//  PRIORITY_MODE  0   0 = round-robin between ports; 1 = fixed priority, port 0 always wins
// PORTS
//  clk         in   1       system clock, all logic on posedge
//  reset       in   1       synchronous, active-high reset
//  p0_req      in   1       port 0 request; held with p0_we/addr/wdata until p0_done
//  p0_we       in   1       port 0: 1 = write, 0 = read
//  p0_addr     in   ADDR_W  port 0 address
//  p0_wdata    in   DATA_W  port 0 write data
//  p0_done     out  1       one-cycle pulse: port 0 access retired
//  p0_rdata    out  DATA_W  port 0 read result, valid when p0_done=1, held until next p0 read
//  p1_*        -    -       identical set for port 1 (p1_req, p1_we, p1_addr, p1_wdata, p1_done, p1_rdata)
//  mem_read    out  1       to Memory_Interface mem_read
//  mem_write   out  1       to Memory_Interface mem_write
//  mem_addr    out  ADDR_W  to Memory_Interface address
//  mem_wdata   out  DATA_W  to Memory_Interface write_data
//  mem_rdata   in   DATA_W  from Memory_Interface read_data
//  busy        out  1       1 whenever state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, last_grant=port 1, so port 0 wins the first tie.
//    All outputs are 0: mem_read, mem_write, mem_addr, mem_wdata, p0/p1_done, p0/p1_rdata, busy.
//  - All outputs are registered. FSM: IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE. Every access takes 4 states.
//  - IDLE: sample requests.
//    If exactly one port requests, grant it.
//    If both request: with PRIORITY_MODE=0, grant the port != last_grant; with PRIORITY_MODE=1, grant port 0.
//    On a grant: latch owner, owner_we, addr, wdata; load mem_addr/mem_wdata; set mem_read=~we, mem_write=we;
//    update last_grant; go to ISSUE. If no request, stay in IDLE with mem_read=mem_write=0.
//  - ISSUE (1 cycle): mem_read or mem_write is high for exactly this cycle.
//    The memory performs the access at the closing edge. The block then clears mem_read/mem_write and goes to CAPTURE.
//  - CAPTURE: mem_rdata is valid (memory read latency is 1).
//    For a read, latch mem_rdata into owner's pX_rdata and assert owner's pX_done.
//    For a write, pX_rdata is unchanged and pX_done is asserted. Go to RESP.
//  - RESP: pX_done high for exactly this cycle; requests are ignored; go to IDLE.
//  - Latency: request seen in IDLE at cycle N -> mem strobe in N+1 -> done in N+3.
//    Maximum throughput is one access per 4 cycles.
//  - Requester protocol: hold req and payload stable until done; deassert req at the edge ending the done cycle.
//    A req still high in the following IDLE cycle is a new access.
//  - Request changes after grant (req dropped, addr changed) are ignored. The latched access completes and done still pulses.
//  - The loser of a tie waits and is granted in the next IDLE cycle if still requesting.
//    Under round-robin, neither port waits more than one access.
//  - Addresses pass through unmodified at full ADDR_W. Wrap to 16 locations is the memory's addr[3:0] decode.
//    No range check in this block.
//  - Reset mid-access (any state): outputs cleared next cycle and state=IDLE; no done is issued for the aborted access.
//    A write already strobed in ISSUE is not undone.
//  - Only one pX_done is high in any cycle. mem_read and mem_write are never both high.
// TESTING
//  1. Reset held 2 cycles, then released with no requests -> all outputs 0, busy=0, no mem strobes for 10 cycles.
//  2. p0 write addr 5 data 0x1A2B3, then p0 read addr 5 -> mem_write 1 cycle;
//     read returns p0_rdata=0x1A2B3 with p0_done 3 cycles after req sampled.
//  3. p0 and p1 both read in same IDLE cycle after reset -> p0 served first, p1 done 4 cycles later.
//     Repeat the tie -> p1 first (round-robin). With PRIORITY_MODE=1 -> p0 first both times.
//  4. p1 write addr 0x12 data 0x7FFFF, then p0 read addr 0x02 -> p0_rdata=0x7FFFF (low-nibble alias).
//  5. Assert reset during ISSUE of a p1 read -> no p1_done, outputs 0 next cycle, state IDLE.
//     A new p1 read then completes normally.
//  6. p0 drops req the cycle after grant, with p0_addr changed -> access completes at the latched address, p0_done pulses once.

Source files
------------

// File: rtl/mem_access_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port memory.
interface mem_access_arbiter_if #(
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned DATA_W = 19
);
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_done;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_done;
    logic [DATA_W-1:0] p1_rdata;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  mem_rdata,
        output p0_done, p0_rdata, p1_done, p1_rdata,
        output mem_read, mem_write, mem_addr, mem_wdata
    );

    // Requesters plus memory side
    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output mem_rdata,
        input  p0_done, p0_rdata, p1_done, p1_rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_access_arbiter.sv
// Two-port round-robin / fixed-priority sequencer in front of a single-port memory
// with one-cycle registered read latency; every access walks IDLE->ISSUE->CAPTURE->RESP.
module mem_access_arbiter #(
    parameter int unsigned ADDR_W        = 19,
    parameter int unsigned DATA_W        = 19,
    parameter int unsigned PRIORITY_MODE = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_access_arbiter_if.slave  bus,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              owner_we_q, owner_we_d;
    logic              last_grant_q, last_grant_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              p0_done_q, p0_done_d;
    logic              p1_done_q, p1_done_d;
    logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
    logic              busy_q, busy_d;

    logic              grant_valid;
    logic              grant_port;
    logic              grant_we;

    // Arbitration: a lone requester wins; a tie goes to the port not granted last, or port 0 in fixed mode
    always_comb begin
        grant_valid = bus.p0_req | bus.p1_req;
        if (bus.p0_req && bus.p1_req) begin
            grant_port = (PRIORITY_MODE != 0) ? 1'b0 : ~last_grant_q;
        end else begin
            grant_port = bus.p1_req;
        end
        grant_we = grant_port ? bus.p1_we : bus.p0_we;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        owner_we_d   = owner_we_q;
        last_grant_d = last_grant_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        p0_done_d    = 1'b0;
        p1_done_d    = 1'b0;
        p0_rdata_d   = p0_rdata_q;
        p1_rdata_d   = p1_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (grant_valid) begin
                    owner_d      = grant_port;
                    owner_we_d   = grant_we;
                    last_grant_d = grant_port;
                    mem_addr_d   = grant_port ? bus.p1_addr  : bus.p0_addr;
                    mem_wdata_d  = grant_port ? bus.p1_wdata : bus.p0_wdata;
                    mem_read_d   = ~grant_we;
                    mem_write_d  = grant_we;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                // Memory read data became valid at the edge that closed ISSUE
                if (owner_q) begin
                    p1_done_d = 1'b1;
                    if (!owner_we_q) p1_rdata_d = bus.mem_rdata;
                end else begin
                    p0_done_d = 1'b1;
                    if (!owner_we_q) p0_rdata_d = bus.mem_rdata;
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            owner_we_q   <= 1'b0;
            last_grant_q <= 1'b1;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            p0_done_q    <= 1'b0;
            p1_done_q    <= 1'b0;
            p0_rdata_q   <= '0;
            p1_rdata_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            owner_we_q   <= owner_we_d;
            last_grant_q <= last_grant_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            p0_done_q    <= p0_done_d;
            p1_done_q    <= p1_done_d;
            p0_rdata_q   <= p0_rdata_d;
            p1_rdata_q   <= p1_rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.p0_done   = p0_done_q;
    assign bus.p1_done   = p1_done_q;
    assign bus.p0_rdata  = p0_rdata_q;
    assign bus.p1_rdata  = p1_rdata_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level timing model.
module tb_mem_access_arbiter;
    localparam int unsigned AW   = 19;
    localparam int unsigned DW   = 19;
    localparam int unsigned MODE = 0;

    logic clk;
    logic reset;
    logic busy;
    logic busy_fp;

    mem_access_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    mem_access_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_fp ();

    mem_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIORITY_MODE(MODE)) dut (
        .clk(clk), .reset(reset), .bus(bus), .busy(busy)
    );

    mem_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIORITY_MODE(1)) dut_fp (
        .clk(clk), .reset(reset), .bus(bus_fp), .busy(busy_fp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fixed-priority instance sees the same requester stimulus
    assign bus_fp.p0_req   = bus.p0_req;
    assign bus_fp.p0_we    = bus.p0_we;
    assign bus_fp.p0_addr  = bus.p0_addr;
    assign bus_fp.p0_wdata = bus.p0_wdata;
    assign bus_fp.p1_req   = bus.p1_req;
    assign bus_fp.p1_we    = bus.p1_we;
    assign bus_fp.p1_addr  = bus.p1_addr;
    assign bus_fp.p1_wdata = bus.p1_wdata;

    // 16-entry memories with registered read data, decoding addr[3:0]
    logic [DW-1:0] mem_a [16];
    logic [DW-1:0] mem_b [16];
    logic [DW-1:0] mrd_a;
    logic [DW-1:0] mrd_b;

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        mrd_a = '0;
        mrd_b = '0;
    end

    always @(posedge clk) begin
        if (bus.mem_write) mem_a[bus.mem_addr[3:0]] <= bus.mem_wdata;
        if (bus.mem_read)  mrd_a <= mem_a[bus.mem_addr[3:0]];
        if (bus_fp.mem_write) mem_b[bus_fp.mem_addr[3:0]] <= bus_fp.mem_wdata;
        if (bus_fp.mem_read)  mrd_b <= mem_b[bus_fp.mem_addr[3:0]];
    end

    assign bus.mem_rdata    = mrd_a;
    assign bus_fp.mem_rdata = mrd_b;

    // Reference model state
    int            checks;
    int            passed;
    int            cyc;
    bit            rst_prev;
    bit            have_txn;
    bit            t_owner;
    bit            t_we;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata;
    int            t_g;
    logic [DW-1:0] exp_rdata [2];
    bit            last_grant;
    logic [DW-1:0] mref [16];
    bit            pend [2];
    bit            granted [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic set_port(input int p, input bit r, input bit we,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            bus.p0_req = r; bus.p0_we = we; bus.p0_addr = a; bus.p0_wdata = d;
        end else begin
            bus.p1_req = r; bus.p1_we = we; bus.p1_addr = a; bus.p1_wdata = d;
        end
    endtask

    // Advance the model by the current cycle's inputs: grant at g => strobe g+1, done g+3, idle g+4
    task automatic model_step();
        int rel;
        bit own;
        if (have_txn) begin
            rel = cyc - t_g;
            if (rel == 1 && t_we) mref[t_addr[3:0]] = t_wdata;
            if (!reset && rel == 2 && !t_we) exp_rdata[t_owner] = mref[t_addr[3:0]];
            if (rel == 3 || reset) begin
                pend[t_owner] = 1'b0;
                have_txn = 1'b0;
            end
        end else if (!reset && (bus.p0_req || bus.p1_req)) begin
            if (bus.p0_req && bus.p1_req) own = (MODE != 0) ? 1'b0 : ~last_grant;
            else own = bus.p1_req;
            have_txn   = 1'b1;
            t_owner    = own;
            t_we       = own ? bus.p1_we : bus.p0_we;
            t_addr     = own ? bus.p1_addr : bus.p0_addr;
            t_wdata    = own ? bus.p1_wdata : bus.p0_wdata;
            t_g        = cyc;
            last_grant = own;
            pend[own]    = 1'b1;
            granted[own] = 1'b1;
        end
        if (reset) begin
            exp_rdata[0] = '0;
            exp_rdata[1] = '0;
            last_grant   = 1'b1;
            have_txn     = 1'b0;
        end
        rst_prev = reset;
    endtask

    task automatic compare();
        bit e_rd, e_wr, e_busy, e_d0, e_d1;
        int rel;
        e_rd = 1'b0; e_wr = 1'b0; e_busy = 1'b0; e_d0 = 1'b0; e_d1 = 1'b0;
        if (!rst_prev && have_txn) begin
            rel    = cyc - t_g;
            e_rd   = (rel == 1) && !t_we;
            e_wr   = (rel == 1) && t_we;
            e_busy = (rel >= 1) && (rel <= 3);
            e_d0   = (rel == 3) && !t_owner;
            e_d1   = (rel == 3) && t_owner;
        end
        check("mem_read",  32'(bus.mem_read),  32'(e_rd));
        check("mem_write", 32'(bus.mem_write), 32'(e_wr));
        check("busy",      32'(busy),          32'(e_busy));
        check("p0_done",   32'(bus.p0_done),   32'(e_d0));
        check("p1_done",   32'(bus.p1_done),   32'(e_d1));
        check("p0_rdata",  32'(bus.p0_rdata),  32'(exp_rdata[0]));
        check("p1_rdata",  32'(bus.p1_rdata),  32'(exp_rdata[1]));
        if (e_rd || e_wr) begin
            check("mem_addr",  32'(bus.mem_addr),  32'(t_addr));
            check("mem_wdata", 32'(bus.mem_wdata), 32'(t_wdata));
        end
        if (rst_prev) begin
            check("mem_addr_rst",  32'(bus.mem_addr),  32'd0);
            check("mem_wdata_rst", 32'(bus.mem_wdata), 32'd0);
        end
        check("strobe_excl", 32'(bus.mem_read & bus.mem_write), 32'd0);
        check("done_excl",   32'(bus.p0_done & bus.p1_done),    32'd0);
    endtask

    // Inputs already set for the current cycle; step model, move to next cycle, check outputs
    task automatic tick();
        model_step();
        @(negedge clk);
        cyc++;
        compare();
    endtask

    task automatic gen_port(input int p);
        if (!pend[p]) begin
            if ($urandom_range(0, 99) < 35) begin
                pend[p] = 1'b1;
                granted[p] = 1'b0;
                set_port(p, 1'b1, 1'($urandom), AW'($urandom), DW'($urandom));
            end else begin
                set_port(p, 1'b0, 1'($urandom), AW'($urandom), DW'($urandom));
            end
        end else if (granted[p] && $urandom_range(0, 7) == 0) begin
            // Payload changes after grant must be ignored
            set_port(p, 1'b0, 1'($urandom), AW'($urandom), DW'($urandom));
        end
    endtask

    initial begin
        int ndone;
        checks = 0; passed = 0; cyc = 0;
        rst_prev = 1'b1; have_txn = 1'b0; last_grant = 1'b1;
        t_owner = 1'b0; t_we = 1'b0; t_addr = '0; t_wdata = '0; t_g = 0;
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        for (int i = 0; i < 16; i++) mref[i] = '0;
        pend[0] = 1'b0; pend[1] = 1'b0; granted[0] = 1'b0; granted[1] = 1'b0;
        reset = 1'b1;
        set_port(0, 1'b0, 1'b0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0);

        @(negedge clk);
        compare();

        // Reset for two edges, then quiet
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t1_quiet", 32'({busy, bus.mem_read, bus.mem_write, bus.p0_done, bus.p1_done}), 32'd0);
        end
        check("t1_rdata", 32'({bus.p0_rdata, bus.p1_rdata}), 32'd0);

        // p0 write then read back
        set_port(0, 1'b1, 1'b1, AW'(5), DW'('h1A2B3));
        tick();
        check("t2_wr_strobe", 32'(bus.mem_write), 32'd1);
        check("t2_wr_addr",   32'(bus.mem_addr),  32'd5);
        check("t2_wr_data",   32'(bus.mem_wdata), 32'h1A2B3);
        tick();
        check("t2_wr_one_cycle", 32'(bus.mem_write), 32'd0);
        tick();
        check("t2_wr_done", 32'(bus.p0_done), 32'd1);
        tick();
        set_port(0, 1'b1, 1'b0, AW'(5), DW'(0));
        tick();
        check("t2_rd_strobe", 32'(bus.mem_read), 32'd1);
        tick();
        check("t2_rd_early", 32'(bus.p0_done), 32'd0);
        tick();
        check("t2_rd_done", 32'(bus.p0_done),  32'd1);
        check("t2_rd_data", 32'(bus.p0_rdata), 32'h1A2B3);
        tick();
        set_port(0, 1'b0, 1'b0, '0, '0);
        tick();

        // Ties after reset: round-robin alternates, fixed priority keeps port 0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_port(0, 1'b1, 1'b0, AW'(1), '0);
        set_port(1, 1'b1, 1'b0, AW'(2), '0);
        tick(); tick(); tick();
        check("t3_tie1_p0",      32'(bus.p0_done),    32'd1);
        check("t3_tie1_p1_wait", 32'(bus.p1_done),    32'd0);
        check("t3_fp_tie1_p0",   32'(bus_fp.p0_done), 32'd1);
        check("t3_fp_tie1_p1",   32'(bus_fp.p1_done), 32'd0);
        tick();
        set_port(0, 1'b1, 1'b0, AW'(3), '0);
        tick(); tick(); tick();
        check("t3_tie2_p1",      32'(bus.p1_done),    32'd1);
        check("t3_tie2_p0_wait", 32'(bus.p0_done),    32'd0);
        check("t3_fp_tie2_p0",   32'(bus_fp.p0_done), 32'd1);
        check("t3_fp_tie2_p1",   32'(bus_fp.p1_done), 32'd0);
        tick();
        set_port(1, 1'b0, 1'b0, '0, '0);
        tick(); tick(); tick();
        check("t3_p0_after", 32'(bus.p0_done), 32'd1);
        tick();
        set_port(0, 1'b0, 1'b0, '0, '0);
        tick();

        // Low-nibble aliasing: 0x12 and 0x02 hit the same location
        set_port(1, 1'b1, 1'b1, AW'('h12), DW'('h7FFFF));
        tick(); tick(); tick();
        check("t4_wr_done", 32'(bus.p1_done), 32'd1);
        tick();
        set_port(1, 1'b0, 1'b0, '0, '0);
        set_port(0, 1'b1, 1'b0, AW'('h02), '0);
        tick(); tick(); tick();
        check("t4_rd_done",  32'(bus.p0_done),  32'd1);
        check("t4_rd_alias", 32'(bus.p0_rdata), 32'h7FFFF);
        tick();
        set_port(0, 1'b0, 1'b0, '0, '0);
        tick();

        // Reset during ISSUE aborts the access; the still-held request restarts
        set_port(1, 1'b1, 1'b0, AW'('h02), '0);
        tick();
        check("t5_issue", 32'(bus.mem_read), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_cleared", 32'({busy, bus.mem_read, bus.mem_write, bus.p0_done, bus.p1_done}), 32'd0);
        check("t5_rdata_cleared", 32'({bus.p0_rdata, bus.p1_rdata}), 32'd0);
        tick();
        check("t5_no_done_a", 32'(bus.p1_done), 32'd0);
        tick();
        check("t5_no_done_b", 32'(bus.p1_done), 32'd0);
        tick();
        check("t5_redo_done", 32'(bus.p1_done),  32'd1);
        check("t5_redo_data", 32'(bus.p1_rdata), 32'h7FFFF);
        tick();
        set_port(1, 1'b0, 1'b0, '0, '0);
        tick();

        // Request dropped and address changed after grant
        set_port(0, 1'b1, 1'b0, AW'(5), '0);
        tick();
        check("t6_addr_latched", 32'(bus.mem_addr), 32'd5);
        set_port(0, 1'b0, 1'b0, AW'(3), '0);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            ndone += int'(bus.p0_done);
        end
        check("t6_one_done", 32'(ndone), 32'd1);
        check("t6_rdata",    32'(bus.p0_rdata), 32'h1A2B3);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            gen_port(0);
            gen_port(1);
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
